seq_mem_arbiter: RTL and testbench

- Owns the Simon Says colour-sequence storage: a single-port array of 2-bit colours.
- Arbitrates it between three requesters, one access per cycle:
  - the colour generator, which appends one colour per round;
  - the sequence-playback engine;
  - the player-check logic.
- Tracks the stored sequence length and performs a multi-cycle scrub on clear.
- Sits between the game FSM/counters and the storage, replacing the ad-hoc direct indexing of the colour memory.

---
 rtl/simon_pkg.sv | 23 ++
 rtl/seq_mem_arbiter_if.sv | 37 +++
 rtl/counter.sv | 20 ++
 rtl/seq_mem_ram.sv | 25 ++
 rtl/seq_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_seq_mem_arbiter.sv | 165 ++++++++++++++++
 6 files changed

// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared colour, arbiter-state and requester types for the sequence store
package simon_pkg;

    localparam int SEQ_DEPTH = 251;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } color_t;

    typedef enum logic {
        RUN   = 1'b0,
        SCRUB = 1'b1
    } arb_state_t;

    typedef enum logic {
        PLAY = 1'b0,
        CHK  = 1'b1
    } requester_t;

endpackage

// File: rtl/seq_mem_arbiter_if.sv
// rtl/seq_mem_arbiter_if.sv - requester/arbiter bundle for the colour-sequence store
interface seq_mem_arbiter_if #(
    parameter int AW = 8
);
    logic          clr;
    logic          wr_req;
    logic [1:0]    wr_color;
    logic          wr_gnt;
    logic          play_req;
    logic [AW-1:0] play_addr;
    logic          play_gnt;
    logic          play_vld;
    logic [1:0]    play_color;
    logic          chk_req;
    logic [AW-1:0] chk_addr;
    logic          chk_gnt;
    logic          chk_vld;
    logic [1:0]    chk_color;
    logic [AW-1:0] len;
    logic          full;
    logic          empty;
    logic          busy;
    logic          ovf;
    logic          oob;

    modport master (
        output clr, wr_req, wr_color, play_req, play_addr, chk_req, chk_addr,
        input  wr_gnt, play_gnt, play_vld, play_color, chk_gnt, chk_vld, chk_color,
        input  len, full, empty, busy, ovf, oob
    );

    modport slave (
        input  clr, wr_req, wr_color, play_req, play_addr, chk_req, chk_addr,
        output wr_gnt, play_gnt, play_vld, play_color, chk_gnt, chk_vld, chk_color,
        output len, full, empty, busy, ovf, oob
    );
endinterface

// File: rtl/counter.sv
// rtl/counter.sv - up counter with enable and synchronous clear
module counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         rst_sync,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (rst_sync) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/seq_mem_ram.sv
// rtl/seq_mem_ram.sv - single-port colour array, synchronous write, registered read data
import simon_pkg::*;

module seq_mem_ram #(
    parameter int DEPTH = SEQ_DEPTH,
    parameter int IW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [IW-1:0] addr,
    input  color_t        wdata,
    output color_t        rdata
);
    color_t mem [DEPTH];

    // Contents are deliberately not reset; rdata holds until the next read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/seq_mem_arbiter.sv
// rtl/seq_mem_arbiter.sv - arbitrates append/playback/check access to the colour store and scrubs it on clear
import simon_pkg::*;

module seq_mem_arbiter #(
    parameter int DEPTH = SEQ_DEPTH,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    seq_mem_arbiter_if.slave bus
);
    localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] DEPTH_V  = AW'(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    arb_state_t    state;
    requester_t    rr_last;
    logic [AW-1:0] len;
    logic          busy_r;
    logic          play_vld_r;
    logic          chk_vld_r;
    logic          oob_r;

    logic          scrubbing;
    logic          scrub_last;
    logic [IW-1:0] scrub_idx;
    logic          run_idle;
    logic          full;
    logic          wr_gnt;
    logic          wr_do;
    logic          play_gnt;
    logic          chk_gnt;
    logic          rd_gnt;
    logic [AW-1:0] rd_addr;

    logic          ram_we;
    logic          ram_re;
    logic [IW-1:0] ram_addr;
    color_t        ram_wdata;
    color_t        ram_rdata;

    assign full       = (len == DEPTH_V);
    assign scrubbing  = (state == SCRUB);
    assign scrub_last = scrubbing && (scrub_idx == LAST_IDX);

    // Writer first, then the lone reader, else the reader that did not win last.
    always_comb begin
        run_idle = (state == RUN) && !bus.clr;
        wr_gnt   = run_idle && bus.wr_req;
        play_gnt = run_idle && !bus.wr_req && bus.play_req && (!bus.chk_req || rr_last == CHK);
        chk_gnt  = run_idle && !bus.wr_req && bus.chk_req && (!bus.play_req || rr_last == PLAY);
        rd_gnt   = play_gnt || chk_gnt;
        rd_addr  = play_gnt ? bus.play_addr : bus.chk_addr;
        wr_do    = wr_gnt && !full;
    end

    // Reads at or past len never touch the array, so the index stays in range.
    always_comb begin
        ram_we    = scrubbing || wr_do;
        ram_re    = rd_gnt && (rd_addr < len);
        ram_wdata = scrubbing ? RED : color_t'(bus.wr_color);
        if (scrubbing) begin
            ram_addr = scrub_idx;
        end else if (wr_do) begin
            ram_addr = len[IW-1:0];
        end else begin
            ram_addr = rd_addr[IW-1:0];
        end
    end

    counter #(.W(IW)) u_scrub_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (scrubbing),
        .rst_sync (scrub_last),
        .count    (scrub_idx)
    );

    seq_mem_ram #(.DEPTH(DEPTH), .IW(IW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            busy_r     <= 1'b0;
            len        <= '0;
            rr_last    <= CHK;
            play_vld_r <= 1'b0;
            chk_vld_r  <= 1'b0;
            oob_r      <= 1'b0;
        end else begin
            play_vld_r <= play_gnt;
            chk_vld_r  <= chk_gnt;
            oob_r      <= rd_gnt && (rd_addr >= len);
            if (chk_gnt) begin
                rr_last <= CHK;
            end else if (play_gnt) begin
                rr_last <= PLAY;
            end
            case (state)
                RUN: begin
                    if (bus.clr) begin
                        state  <= SCRUB;
                        busy_r <= 1'b1;
                        len    <= '0;
                    end else if (wr_do) begin
                        len <= len + 1'b1;
                    end
                end
                SCRUB: begin
                    if (scrub_last) begin
                        state  <= RUN;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_gnt     = wr_gnt;
    assign bus.play_gnt   = play_gnt;
    assign bus.chk_gnt    = chk_gnt;
    assign bus.play_vld   = play_vld_r;
    assign bus.chk_vld    = chk_vld_r;
    assign bus.play_color = (play_vld_r && !oob_r) ? ram_rdata : RED;
    assign bus.chk_color  = (chk_vld_r && !oob_r) ? ram_rdata : RED;
    assign bus.len        = len;
    assign bus.full       = full;
    assign bus.empty      = (len == '0);
    assign bus.busy       = busy_r;
    assign bus.ovf        = wr_gnt && full;
    assign bus.oob        = oob_r;
endmodule

// File: tb/tb_seq_mem_arbiter.sv
// tb/tb_seq_mem_arbiter.sv - directed vector bench for seq_mem_arbiter at DEPTH=4
module tb_seq_mem_arbiter;
    import simon_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_mem_arbiter_if #(.AW(AW)) bus ();

    seq_mem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    typedef struct {
        logic          clr;
        logic          wr;
        logic [1:0]    wc;
        logic          pr;
        logic [AW-1:0] pa;
        logic          cr;
        logic [AW-1:0] ca;
        logic [2:0]    gnt;
        logic [2:0]    play;
        logic [2:0]    chk;
        logic [AW-1:0] len;
        logic [4:0]    flags;
    } vec_t;

    int   n_run  = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    // gnt = {wr,play,chk}; play/chk = {vld,color}; flags = {full,empty,busy,ovf,oob}
    function automatic vec_t mk(input int clr, input int wr, input int wc, input int pr, input int pa,
                                input int cr, input int ca, input int wg, input int pg, input int cg,
                                input int pv, input int pc, input int cv, input int cc,
                                input int len, input int fl);
        vec_t v;
        v.clr   = 1'(clr);
        v.wr    = 1'(wr);
        v.wc    = 2'(wc);
        v.pr    = 1'(pr);
        v.pa    = AW'(pa);
        v.cr    = 1'(cr);
        v.ca    = AW'(ca);
        v.gnt   = {1'(wg), 1'(pg), 1'(cg)};
        v.play  = {1'(pv), 2'(pc)};
        v.chk   = {1'(cv), 2'(cc)};
        v.len   = AW'(len);
        v.flags = 5'(fl);
        return v;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.clr       = v.clr;
        bus.wr_req    = v.wr;
        bus.wr_color  = v.wc;
        bus.play_req  = v.pr;
        bus.play_addr = v.pa;
        bus.chk_req   = v.cr;
        bus.chk_addr  = v.ca;
    endtask

    task automatic apply(input vec_t v, input string tag);
        drive(v);
        #1;
        check({tag, " gnt"},   8'({bus.wr_gnt, bus.play_gnt, bus.chk_gnt}), 8'(v.gnt));
        check({tag, " play"},  8'({bus.play_vld, bus.play_color}), 8'(v.play));
        check({tag, " chk"},   8'({bus.chk_vld, bus.chk_color}), 8'(v.chk));
        check({tag, " len"},   8'(bus.len), 8'(v.len));
        check({tag, " flags"}, 8'({bus.full, bus.empty, bus.busy, bus.ovf, bus.oob}), 8'(v.flags));
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Append RED..YELLOW, read back, overflow, out-of-bounds, round-robin, contention.
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01000));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5'b01000));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 5'b00000));
        vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 5'b00000));
        vecs.push_back(mk(0, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 5'b00000));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4, 5'b10000));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 4, 5'b10000));
        vecs.push_back(mk(0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 1, 1, 0, 0, 4, 5'b10000));
        vecs.push_back(mk(0, 0, 0, 1, 3, 0, 0, 0, 1, 0, 1, 2, 0, 0, 4, 5'b10000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 4, 5'b10000));
        vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4, 5'b10010));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 4, 0, 0, 1, 0, 0, 0, 0, 4, 5'b10000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4, 5'b10001));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 4, 5'b10000));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 4, 5'b10000));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 4, 5'b10000));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 4, 5'b10000));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 4, 5'b10000));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 4, 5'b10000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 5'b10000));
        vecs.push_back(mk(0, 1, 0, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0, 4, 5'b10010));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1, 3, 0, 1, 0, 0, 0, 0, 0, 4, 5'b10000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3, 0, 0, 1, 1, 2, 0, 0, 4, 5'b10000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 4, 5'b10000));

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("row%0d", i));
        end

        // Scrub with a playback request pending; a clr inside the scrub is ignored.
        apply(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 5'b10000), "clr");
        for (int k = 1; k <= DEPTH; k++) begin
            apply(mk((k == 2) ? 1 : 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01100),
                  $sformatf("scrub%0d", k));
        end
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5'b01000), "scrub_end");
        apply(mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 5'b01001), "app0");
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 5'b00000), "rd0");
        apply(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 5'b00000), "rd1");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5'b00001), "rd1_oob");

        // Asynchronous reset in the second scrub cycle.
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000), "clr2");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01100), "scrub2_1");
        rst_n = 1'b0;
        #1;
        check("rst busy", 8'(bus.busy), 8'd0);
        check("rst len", 8'(bus.len), 8'd0);
        check("rst full_empty", 8'({bus.full, bus.empty}), 8'b01);
        repeat (2) @(posedge clk);
        #1;
        check("rst vld", 8'({bus.play_vld, bus.chk_vld}), 8'd0);
        rst_n = 1'b1;
        drive(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("rst_resume gnt", 8'({bus.wr_gnt, bus.play_gnt, bus.chk_gnt}), 8'b010);
        check("rst_resume busy", 8'(bus.busy), 8'd0);
        @(posedge clk);
        #1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("rst_resume play", 8'({bus.play_vld, bus.play_color}), 8'b100);
        check("rst_resume oob", 8'(bus.oob), 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
